bsk_ntw_server_mk: RTL

Multi-key, parametrised bootstrapping-key distribution server for the NTT core's BSK network. It stores one slice of up to KEY_NB bootstrapping keys (a contiguous br_loop range per key) in banked 1R1W RAMs. On each broadcast batch command it streams the addressed key slice onto a shared, zero-when-idle broadcast bus. It stays in lock-step with its neighbour servers through a global iteration pointer.

---
 rtl/bsk_ntw_server_mk.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bsk_ntw_server_mk.sv
`default_nettype none
// ============================================================================
// Module   : bsk_ntw_server_mk
// Purpose  : Multi-key bootstrapping-key distribution server. Stores one
//            br_loop slice of up to KEY_NB keys in banked 1R1W RAMs and
//            streams the addressed slice onto a zero-when-idle broadcast bus,
//            kept in lock-step with neighbour servers by a global pointer.
// Options  : BSK_SRV_KEY_LOCK_EN - drop host writes into the key slot that is
//            currently being broadcast, and flag them on error[2].
// Revision : 1.0 - initial release
// ============================================================================
module bsk_ntw_server_mk #(
    parameter int OP_W            = 32,
    parameter int COEF_NB         = 8,
    parameter int RAM_W           = 72,
    parameter int KEY_NB          = 2,
    parameter int ITER_NB         = 64,
    parameter int BR_LOOP_W       = 10,
    parameter int BR_LOOP_OFS     = 0,
    parameter int BR_LOOP_NB      = 98,
    parameter int NEIGH_SERVER_NB = 2,
    parameter int CMD_FIFO_DEPTH  = 4,
    parameter int RAM_LATENCY     = 3,
    parameter int ITER_W          = $clog2(ITER_NB),
    parameter int ADD_W           = $clog2(BR_LOOP_NB * ITER_NB),
    parameter int KID_W           = (KEY_NB > 1) ? $clog2(KEY_NB) : 1
) (
    input  logic                       clk,
    input  logic                       a_rst_n,
    input  logic [BR_LOOP_W-1:0]       cmd_br_loop,
    input  logic [KID_W-1:0]           cmd_key_id,
    input  logic                       cmd_avail,
    input  logic [NEIGH_SERVER_NB-1:0] neigh_srv_bdc_avail,
    input  logic                       wr_en,
    input  logic [KID_W-1:0]           wr_key_id,
    input  logic [ADD_W-1:0]           wr_add,
    input  logic [COEF_NB*OP_W-1:0]    wr_data,
    output logic [COEF_NB*OP_W-1:0]    srv_bdc_bsk,
    output logic [COEF_NB-1:0]         srv_bdc_avail,
    output logic [ITER_W-1:0]          srv_bdc_iter,
    output logic [BR_LOOP_W-1:0]       srv_bdc_br_loop,
    output logic [KID_W-1:0]           srv_bdc_key_id,
    output logic [2:0]                 error
);

    localparam int RD_NB  = RAM_W / OP_W;
    localparam int RAM_NB = (COEF_NB + RD_NB - 1) / RD_NB;
    localparam int BANK_W = RD_NB * OP_W;  // pad bits of the physical word are not stored
    localparam int DEPTH  = KEY_NB * BR_LOOP_NB * ITER_NB;
    localparam int DEP_W  = $clog2(DEPTH);
    localparam int DATA_W = COEF_NB * OP_W;
    localparam int FP_W   = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(CMD_FIFO_DEPTH + 1);
    localparam logic [DEP_W-1:0] KEY_SPAN = DEP_W'(BR_LOOP_NB * ITER_NB);

    // ---------------- command decode ----------------
    logic [BR_LOOP_W:0] cmd_rel;
    logic               cmd_in_range;
    logic               cmd_key_ok;
    logic [DEP_W-1:0]   cmd_base;

    // A br_loop below the offset wraps into the extra MSB and so fails the range test.
    assign cmd_rel      = {1'b0, cmd_br_loop} - (BR_LOOP_W+1)'(BR_LOOP_OFS);
    assign cmd_in_range = cmd_rel < (BR_LOOP_W+1)'(BR_LOOP_NB);
    assign cmd_key_ok   = {1'b0, cmd_key_id} < (KID_W+1)'(KEY_NB);
    assign cmd_base     = DEP_W'(cmd_key_id) * KEY_SPAN
                        + DEP_W'(cmd_rel[BR_LOOP_W-1:0]) * DEP_W'(ITER_NB);

    logic                 s1_vld;
    logic [BR_LOOP_W-1:0] s1_br_loop;
    logic [KID_W-1:0]     s1_key_id;
    logic [DEP_W-1:0]     s1_base;
    logic                 s1_do_read;

    // Command capture stage
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            s1_vld     <= 1'b0;
            s1_br_loop <= '0;
            s1_key_id  <= '0;
            s1_base    <= '0;
            s1_do_read <= 1'b0;
        end else begin
            s1_vld     <= cmd_avail;
            s1_br_loop <= cmd_br_loop;
            s1_key_id  <= cmd_key_id;
            s1_base    <= cmd_base;
            s1_do_read <= cmd_in_range & cmd_key_ok;
        end
    end

    // ---------------- command FIFO ----------------
    logic [BR_LOOP_W-1:0] fifo_br_loop [CMD_FIFO_DEPTH];
    logic [KID_W-1:0]     fifo_key_id  [CMD_FIFO_DEPTH];
    logic [DEP_W-1:0]     fifo_base    [CMD_FIFO_DEPTH];
    logic                 fifo_do_read [CMD_FIFO_DEPTH];
    logic [FP_W-1:0]      fifo_wp, fifo_rp;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 fifo_full, push, pop, ovf;

    logic                 head_vld, head_do_read;
    logic [BR_LOOP_W-1:0] head_br_loop;
    logic [KID_W-1:0]     head_key_id;
    logic [DEP_W-1:0]     head_base;

    assign head_vld     = fifo_cnt != '0;
    assign head_do_read = fifo_do_read[fifo_rp];
    assign head_br_loop = fifo_br_loop[fifo_rp];
    assign head_key_id  = fifo_key_id[fifo_rp];
    assign head_base    = fifo_base[fifo_rp];

    assign fifo_full = fifo_cnt == CNT_W'(CMD_FIFO_DEPTH);
    assign push      = s1_vld & (~fifo_full | pop);
    assign ovf       = s1_vld & fifo_full & ~pop;

    // FIFO payload storage (no reset needed, guarded by fifo_cnt)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_br_loop[fifo_wp] <= s1_br_loop;
            fifo_key_id[fifo_wp]  <= s1_key_id;
            fifo_base[fifo_wp]    <= s1_base;
            fifo_do_read[fifo_wp] <= s1_do_read;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                fifo_wp <= (fifo_wp == FP_W'(CMD_FIFO_DEPTH-1)) ? '0 : fifo_wp + FP_W'(1);
            if (pop)
                fifo_rp <= (fifo_rp == FP_W'(CMD_FIFO_DEPTH-1)) ? '0 : fifo_rp + FP_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- global iteration pointer ----------------
    logic              nb_rd, rd_en, gl_inc, gl_last;
    logic [ITER_W-1:0] gl_rp;

    assign rd_en   = head_vld & head_do_read;
    assign gl_inc  = rd_en | nb_rd;
    assign gl_last = gl_rp == ITER_W'(ITER_NB-1);
    assign pop     = gl_inc & gl_last & head_vld;

    // Pointer advances on local reads or on a neighbour beat seen one cycle late
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            nb_rd <= 1'b0;
            gl_rp <= '0;
        end else begin
            nb_rd <= |neigh_srv_bdc_avail;
            if (gl_inc)
                gl_rp <= gl_last ? '0 : gl_rp + ITER_W'(1);
        end
    end

    // ---------------- read address and sideband ----------------
    logic [DEP_W-1:0]     rd_add;
    logic                 sb_vld     [RAM_LATENCY+1];
    logic [BR_LOOP_W-1:0] sb_br_loop [RAM_LATENCY+1];
    logic [KID_W-1:0]     sb_key_id  [RAM_LATENCY+1];
    logic [ITER_W-1:0]    sb_iter    [RAM_LATENCY+1];

    // Read address register shared by all banks
    always_ff @(posedge clk) begin
        if (rd_en)
            rd_add <= head_base + DEP_W'(gl_rp);
    end

    // Sideband delay line matched to address register plus RAM latency
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i <= RAM_LATENCY; i++) begin
                sb_vld[i]     <= 1'b0;
                sb_br_loop[i] <= '0;
                sb_key_id[i]  <= '0;
                sb_iter[i]    <= '0;
            end
        end else begin
            sb_vld[0]     <= rd_en;
            sb_br_loop[0] <= head_br_loop;
            sb_key_id[0]  <= head_key_id;
            sb_iter[0]    <= gl_rp;
            for (int i = 1; i <= RAM_LATENCY; i++) begin
                sb_vld[i]     <= sb_vld[i-1];
                sb_br_loop[i] <= sb_br_loop[i-1];
                sb_key_id[i]  <= sb_key_id[i-1];
                sb_iter[i]    <= sb_iter[i-1];
            end
        end
    end

    // ---------------- host write path ----------------
    logic               wr_q_en;
    logic [KID_W-1:0]   wr_q_key_id;
    logic [ADD_W-1:0]   wr_q_add;
    logic [DATA_W-1:0]  wr_q_data;
    logic               wr_key_ok, lock_hit, wr_ram_en;
    logic [DEP_W-1:0]   wr_ram_add;

    // Write request register
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_q_en     <= 1'b0;
            wr_q_key_id <= '0;
            wr_q_add    <= '0;
            wr_q_data   <= '0;
        end else begin
            wr_q_en     <= wr_en;
            wr_q_key_id <= wr_key_id;
            wr_q_add    <= wr_add;
            wr_q_data   <= wr_data;
        end
    end

    assign wr_key_ok  = {1'b0, wr_q_key_id} < (KID_W+1)'(KEY_NB);
    assign wr_ram_add = DEP_W'(wr_q_key_id) * KEY_SPAN + DEP_W'(wr_q_add);
`ifdef BSK_SRV_KEY_LOCK_EN
    assign lock_hit   = wr_q_en & wr_key_ok & rd_en & (wr_q_key_id == head_key_id);
`else
    assign lock_hit   = 1'b0;
`endif
    assign wr_ram_en  = wr_q_en & wr_key_ok & ~lock_hit;

    // ---------------- RAM banks ----------------
    logic [BANK_W-1:0] bank_q [RAM_NB];

    for (genvar b = 0; b < RAM_NB; b++) begin : g_bank
        logic [BANK_W-1:0] mem  [DEPTH];
        logic [BANK_W-1:0] pipe [RAM_LATENCY];
        logic [BANK_W-1:0] wdata;

        // Slice of the write word owned by this bank
        always_comb begin
            wdata = '0;
            for (int i = 0; i < RD_NB; i++)
                if (b*RD_NB + i < COEF_NB)
                    wdata[i*OP_W +: OP_W] = wr_q_data[(b*RD_NB+i)*OP_W +: OP_W];
        end

        // 1R1W array; same-address read/write returns the old word
        always_ff @(posedge clk) begin
            if (wr_ram_en)
                mem[wr_ram_add] <= wdata;
            pipe[0] <= mem[rd_add];
            for (int i = 1; i < RAM_LATENCY; i++)
                pipe[i] <= pipe[i-1];
        end

        assign bank_q[b] = pipe[RAM_LATENCY-1];
    end

    logic [DATA_W-1:0] rd_data;
    logic              out_vld;

    // Reassemble coefficients from the banks
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < COEF_NB; c++)
            rd_data[c*OP_W +: OP_W] = bank_q[c/RD_NB][(c%RD_NB)*OP_W +: OP_W];
    end

    assign out_vld = sb_vld[RAM_LATENCY];

    // Output register, zero when not driving, plus error pulses
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            srv_bdc_bsk     <= '0;
            srv_bdc_avail   <= '0;
            srv_bdc_iter    <= '0;
            srv_bdc_br_loop <= '0;
            srv_bdc_key_id  <= '0;
            error           <= '0;
        end else begin
            srv_bdc_bsk     <= out_vld ? rd_data : '0;
            srv_bdc_avail   <= {COEF_NB{out_vld}};
            srv_bdc_iter    <= out_vld ? sb_iter[RAM_LATENCY] : '0;
            srv_bdc_br_loop <= out_vld ? sb_br_loop[RAM_LATENCY] : '0;
            srv_bdc_key_id  <= out_vld ? sb_key_id[RAM_LATENCY] : '0;
            error           <= {lock_hit, cmd_avail & ~cmd_key_ok, ovf};
        end
    end

endmodule
`default_nettype wire
